// File: rtl/crypto_wallet_cpu_cpu_pkg.sv
// ---------------------------------------------------------------------------
// crypto_wallet_cpu_cpu_pkg
// Shared definitions for the CPU arithmetic cells.
//   div_state_e   : divider FSM state encoding (IDLE, CALC, FIX, DONE)
//   DIV_LATENCY   : start-to-done latency of the divider at the default width
//   div_latency() : the same latency for an arbitrary operand width
// ---------------------------------------------------------------------------
package crypto_wallet_cpu_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // One cycle per quotient bit, plus the sign-fix cycle and the done cycle.
  localparam int DIV_LATENCY = DIV_WIDTH_DEFAULT + 2;

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/crypto_wallet_cpu_cpu_div_step.sv
// ---------------------------------------------------------------------------
// crypto_wallet_cpu_cpu_div_step
// One combinational iteration of a radix-2 restoring divider.
// Shifts {rem, dvd} left by one, trial-subtracts the divisor and either keeps
// the difference (quotient bit 1) or restores the shifted remainder (bit 0).
// Quotient bits are shifted into the low end of the dividend register.
// Ports:
//   i_rem  : partial remainder (WIDTH)
//   i_dvd  : dividend / quotient shift register (WIDTH)
//   i_dsr  : divisor magnitude (WIDTH)
//   o_rem  : next partial remainder
//   o_dvd  : next dividend / quotient shift register
//   o_qbit : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module crypto_wallet_cpu_cpu_div_step
  import crypto_wallet_cpu_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_dvd[WIDTH-1]};
  // Since the partial remainder always stays below the divisor (or below
  // 2^k after k steps when the divisor is zero), the shifted value is under
  // twice the divisor and the WIDTH+1-bit difference never overflows, so its
  // MSB is a reliable borrow flag.
  assign w_diff  = w_shift - {1'b0, i_dsr};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_dvd   = {i_dvd[WIDTH-2:0], o_qbit};

endmodule

// File: rtl/crypto_wallet_cpu_cpu_div_cell.sv
// ---------------------------------------------------------------------------
// crypto_wallet_cpu_cpu_div_cell
// Iterative radix-2 restoring divider for div/divu. Operands are converted
// to magnitudes at start, divided over WIDTH cycles, sign-fixed in one cycle
// and announced with a one-cycle done pulse (latency WIDTH+2).
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   E_src1     : dividend (WIDTH)
//   E_src2     : divisor (WIDTH)
//   E_start    : start request, sampled only in IDLE
//   E_signed   : 1 = two's-complement divide, sampled with E_start
//   M_abort    : flush, kills a division in CALC or FIX
//   M_div_busy : high from the cycle after start through the done cycle
//   M_div_done : one-cycle result-valid pulse
//   M_div_quot : quotient, held until overwritten by the next result
//   M_div_rem  : remainder, held likewise
//   M_div_dbz  : divide-by-zero flag, held likewise
// ---------------------------------------------------------------------------
module crypto_wallet_cpu_cpu_div_cell
  import crypto_wallet_cpu_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_start,
  input  logic             E_signed,
  input  logic             M_abort,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_dbz
);

  localparam int CW = $clog2(WIDTH);

  div_state_e r_state;
  div_state_e w_state_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_quot_out;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz_out;

  logic             w_sign1;
  logic             w_sign2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_dvd;
  logic             w_step_qbit;

  assign w_sign1 = E_signed & E_src1[WIDTH-1];
  assign w_sign2 = E_signed & E_src2[WIDTH-1];
  assign w_mag1  = w_sign1 ? (~E_src1 + 1'b1) : E_src1;
  assign w_mag2  = w_sign2 ? (~E_src2 + 1'b1) : E_src2;

  crypto_wallet_cpu_cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dsr  (r_dsr),
    .o_rem  (w_step_rem),
    .o_dvd  (w_step_dvd),
    .o_qbit (w_step_qbit)
  );

  // The quotient bit is already folded into w_step_dvd.
  logic w_unused;
  assign w_unused = w_step_qbit;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // An abort arriving together with a start in IDLE is ignored.
        if (E_start) w_state_next = ST_CALC;
      end
      ST_CALC: begin
        if (M_abort)              w_state_next = ST_IDLE;
        else if (r_cnt == '0)     w_state_next = ST_FIX;
      end
      ST_FIX: begin
        if (M_abort) w_state_next = ST_IDLE;
        else         w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
      r_dbz_out  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (E_start) begin
            r_rem      <= '0;
            r_dvd      <= w_mag1;
            r_dsr      <= w_mag2;
            r_neg_q    <= w_sign1 ^ w_sign2;
            r_neg_r    <= w_sign1;
            r_dbz_pend <= (E_src2 == '0);
            r_cnt      <= CW'(WIDTH - 1);
          end
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_dvd <= w_step_dvd;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          if (!M_abort) begin
            // With a zero divisor every trial subtract succeeds, so the
            // iteration itself leaves all ones in the quotient and the
            // dividend magnitude in the remainder; only the remainder gets
            // its sign back.
            if (r_dbz_pend)   r_quot_out <= '1;
            else if (r_neg_q) r_quot_out <= ~r_dvd + 1'b1;
            else              r_quot_out <= r_dvd;
            r_rem_out <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
            r_dbz_out <= r_dbz_pend;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign M_div_busy = (r_state != ST_IDLE);
  assign M_div_done = (r_state == ST_DONE);
  assign M_div_quot = r_quot_out;
  assign M_div_rem  = r_rem_out;
  assign M_div_dbz  = r_dbz_out;

endmodule
